data_mem_port: RTL and testbench
================================

# data_mem_port

Load/store responder at the data-memory end of the pipeline's MemWrite/DataAdr/WriteData store bus. Accepts one load or store request at a time through a valid/ready handshake and performs byte/half/word accesses with RV32I sign or zero extension. Returns a registered response and emits a one-cycle store-observe pulse carrying the merged word written. Drives a sticky completion flag when word 30 is stored to address 40.

## Interface
- DEPTH, 64, number of 32-bit words; power of two
- INIT_FILE, "", hex image loaded with $readmemh when non-empty
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte/half used for sb/sh
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned word access or illegal funct3
- st_valid  out  1  one-cycle pulse after a committed store
- st_addr  out  32  word-aligned address of committed store
- st_data  out  32  full word after merge
- st_count  out  16  committed stores, saturating at 0xFFFF
- done  out  1  sticky: set by a word store of 30 to address 40

## Operation
- States: IDLE, RESP. req_ready = (state == IDLE).
- IDLE: on req_valid & req_ready, capture the request and go to RESP.
- Word index = req_addr[log2(DEPTH)+1:2]. Higher address bits are ignored, so the index wraps modulo DEPTH. Byte offset = req_addr[1:0].
- Byte access: lane = offset.
- Half access: low byte at lane offset, high byte at lane (offset+1) mod 4, wrapping inside the same word.
  - Offset 3 therefore pairs byte 3 (low) with byte 0 (high).
  - Not an error.
- Word access with offset != 0 is an error: no write, rdata 0, resp_err 1.
- Illegal funct3 is an error, with the same effect:
  - loads: 011, 110, 111
  - stores: any funct3 other than 000, 001, 010
- Store: byte-lane writes take effect at the accepting edge.
  - Same edge: st_data is the merged word, st_addr = {req_addr[31:2], 2'b00}.
  - Next cycle: st_valid = 1; st_count increments unless already saturated.
  - done sets if funct3 = 010, req_addr = 40 and req_wdata = 30.
- Load: the word is read at the accepting edge into a register. resp_rdata is extracted and extended from that register:
  - b, h: sign-extend
  - bu, hu: zero-extend
  - w: word unchanged
- RESP: resp_valid = 1, and resp_rdata/resp_err are held stable until resp_ready. On resp_valid & resp_ready, return to IDLE.
- Memory contents are not reset. With INIT_FILE empty, contents are X until written.

## Timing
- Reset (asynchronous, any state): state = IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, st_valid 0, st_addr 0, st_data 0, st_count 0, done 0. Memory is preserved.
- Reset asserted mid-RESP drops the pending response with no ack. A store already committed stays in memory.
- Accept at edge N: resp_valid high from N+1. Stores also pulse st_valid during cycle N+1.
- Fastest throughput: one request per 2 cycles (accept, RESP with resp_ready=1, accept again).
- req_ready is low throughout RESP. req_* inputs are ignored while not ready.
- resp_ready asserted while resp_valid is 0 has no effect.
- Back-to-back store then load of the same word: the load returns the stored data, because the write commits before the next accept.
- st_count stays at 0xFFFF once reached, and st_valid still pulses.
- done is never cleared except by reset.

## Test plan
- Word store/load: sw 0xAA0BC0DD to 96, then lw 96 -> resp_rdata 0xAA0BC0DD. Store cycle: st_valid 1, st_addr 96, st_data 0xAA0BC0DD, st_count 1.
- Byte loads on that word:
  - lb 96/97/98/99 -> -35, -64, 11, -86
  - lbu 96/97/98/99 -> 221, 192, 11, 170
- Half loads with intra-word wrap:
  - lh 96/97/98/99 -> -16163, 3008, -22005, -8790
  - lhu 98 -> 43531; lhu 99 -> 56746
- Byte store merge: sb 0x77 to 99 on word 0xAA0BC0DD -> st_data 0x770BC0DD (1997258973); a following lw 96 returns the same value.
- Errors:
  - lw 98 -> resp_err 1, rdata 0, no st_valid
  - sw 0x12345678 to 98 -> resp_err 1, memory unchanged
  - load funct3 111 -> resp_err 1
- Handshake and flags:
  - Hold resp_ready 0 for 5 cycles: resp_valid and data stable, req_ready 0.
  - sw 30 to 40 -> done 1.
  - reset_n pulsed low mid-RESP -> all outputs at reset values; word 96 still reads 0xAA0BC0DD.

Source files
------------

// File: rtl/data_mem_port.sv
// Single-port data memory responder: one load/store in flight, byte/half/word
// lanes with RV32I extension, registered response and a store-observe pulse.
//
// state | meaning
// IDLE  | ready for a request; stores commit on the accepting edge
// RESP  | response presented, held until resp_ready
module data_mem_port #(
   parameter int    DEPTH     = 64,
   parameter string INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        st_valid,
   output logic [31:0] st_addr,
   output logic [31:0] st_data,
   output logic [15:0] st_count,
   output logic        done
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   logic [31:0] mem [DEPTH];

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;
   logic        err_q, err_d;
   logic [31:0] rd_word_q, rd_word_d;
   logic        st_valid_q, st_valid_d;
   logic [31:0] st_addr_q, st_addr_d;
   logic [31:0] st_data_q, st_data_d;
   logic [15:0] st_count_q, st_count_d;
   logic        done_q, done_d;

   logic          accept;
   logic [AW-1:0] idx;
   logic [1:0]    off;
   logic          f3_illegal;
   logic          err_req;
   logic [31:0]   cur_word;
   logic [31:0]   merged;
   logic          mem_we;

   // Half accesses wrap inside the word: offset 3 pairs lane 3 with lane 0.
   function automatic logic [31:0] merge_word(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  o,
                                              input logic [31:0] wd);
      logic [31:0] r;
      logic [1:0]  o1;
      r  = word;
      o1 = o + 2'd1;
      case (f3)
         3'b000: r[{o, 3'b000} +: 8] = wd[7:0];
         3'b001: begin
            r[{o, 3'b000} +: 8]  = wd[7:0];
            r[{o1, 3'b000} +: 8] = wd[15:8];
         end
         3'b010:  r = wd;
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] extract(input logic [31:0] word,
                                           input logic [2:0]  f3,
                                           input logic [1:0]  o);
      logic [7:0]  lo;
      logic [7:0]  hi;
      logic [1:0]  o1;
      logic [31:0] r;
      o1 = o + 2'd1;
      lo = word[{o, 3'b000} +: 8];
      hi = word[{o1, 3'b000} +: 8];
      case (f3)
         3'b000:  r = {{24{lo[7]}}, lo};
         3'b100:  r = {24'd0, lo};
         3'b001:  r = {{16{hi[7]}}, hi, lo};
         3'b101:  r = {16'd0, hi, lo};
         3'b010:  r = word;
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   assign accept   = req_valid && (state_q == IDLE);
   assign idx      = req_addr[AW+1:2];
   assign off      = req_addr[1:0];
   assign cur_word = mem[idx];
   assign merged   = merge_word(cur_word, req_funct3, off, req_wdata);

   always_comb begin
      f3_illegal = 1'b0;
      if (req_we) begin
         f3_illegal = !(req_funct3 == 3'b000 || req_funct3 == 3'b001 ||
                        req_funct3 == 3'b010);
      end else begin
         f3_illegal = (req_funct3 == 3'b011 || req_funct3 == 3'b110 ||
                       req_funct3 == 3'b111);
      end
      err_req = f3_illegal || (req_funct3 == 3'b010 && off != 2'b00);
   end

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      f3_d       = f3_q;
      off_d      = off_q;
      err_d      = err_q;
      rd_word_d  = rd_word_q;
      st_valid_d = 1'b0;
      st_addr_d  = st_addr_q;
      st_data_d  = st_data_q;
      st_count_d = st_count_q;
      done_d     = done_q;
      mem_we     = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d   = RESP;
               we_d      = req_we;
               f3_d      = req_funct3;
               off_d     = off;
               err_d     = err_req;
               rd_word_d = cur_word;
               if (req_we && !err_req) begin
                  mem_we     = 1'b1;
                  st_valid_d = 1'b1;
                  st_addr_d  = {req_addr[31:2], 2'b00};
                  st_data_d  = merged;
                  if (st_count_q != 16'hFFFF) st_count_d = st_count_q + 16'd1;
                  if (req_funct3 == 3'b010 && req_addr == 32'd40 &&
                      req_wdata == 32'd30) done_d = 1'b1;
               end
            end
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         f3_q       <= 3'b000;
         off_q      <= 2'b00;
         err_q      <= 1'b0;
         rd_word_q  <= 32'd0;
         st_valid_q <= 1'b0;
         st_addr_q  <= 32'd0;
         st_data_q  <= 32'd0;
         st_count_q <= 16'd0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         f3_q       <= f3_d;
         off_q      <= off_d;
         err_q      <= err_d;
         rd_word_q  <= rd_word_d;
         st_valid_q <= st_valid_d;
         st_addr_q  <= st_addr_d;
         st_data_q  <= st_data_d;
         st_count_q <= st_count_d;
         done_q     <= done_d;
      end
   end

   // Memory is deliberately outside the reset domain so contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[idx] <= merged;
   end

   always_comb begin
      resp_rdata = 32'd0;
      if (state_q == RESP && !we_q && !err_q) resp_rdata = extract(rd_word_q, f3_q, off_q);
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_err   = (state_q == RESP) && err_q;
   assign st_valid   = st_valid_q;
   assign st_addr    = st_addr_q;
   assign st_data    = st_data_q;
   assign st_count   = st_count_q;
   assign done       = done_q;

endmodule

// File: tb/tb_data_mem_port.sv
// Directed vector bench for data_mem_port: table of load/store requests plus
// hand-written stall, done-flag and mid-response reset sequences.
module tb_data_mem_port;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [15:0] st_count;
   logic        done;

   int n_tests = 0;
   int n_fail  = 0;
   int exp_count = 0;

   data_mem_port #(.DEPTH(64), .INIT_FILE("")) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
      .st_count(st_count), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      logic        st;
      logic [31:0] sdata;
   } vec_t;

   localparam int NV = 28;
   vec_t vecs [NV];

   function automatic vec_t mk(string n, logic we, logic [2:0] f3, logic [31:0] a,
                               logic [31:0] wd, logic [31:0] rd, logic err,
                               logic st, logic [31:0] sd);
      vec_t v;
      v.name = n; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
      v.rdata = rd; v.err = err; v.st = st; v.sdata = sd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present a request; returns #1 after the accepting edge with inputs released.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
      int waited;
      waited = 0;
      while (!req_ready && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      chk("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'd0; req_wdata = 32'd0;
   endtask

   task automatic finish_resp();
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk("resp_valid_after_ack", {31'd0, resp_valid}, 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"},  {31'd0, req_ready},  32'd1);
      chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
      chk({tag, "_resp_rdata"}, resp_rdata,          32'd0);
      chk({tag, "_resp_err"},   {31'd0, resp_err},   32'd0);
      chk({tag, "_st_valid"},   {31'd0, st_valid},   32'd0);
      chk({tag, "_st_addr"},    st_addr,             32'd0);
      chk({tag, "_st_data"},    st_data,             32'd0);
      chk({tag, "_st_count"},   {16'd0, st_count},   32'd0);
      chk({tag, "_done"},       {31'd0, done},       32'd0);
   endtask

   task automatic load_check(input string n, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] exp);
      issue(1'b0, f3, a, 32'd0);
      chk({n, "_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({n, "_rdata"}, resp_rdata, exp);
      chk({n, "_err"},   {31'd0, resp_err}, 32'd0);
      finish_resp();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk("sw96",   1, 3'b010, 96,  32'hAA0BC0DD, 0, 0, 1, 32'hAA0BC0DD);
      vecs[1]  = mk("lw96",   0, 3'b010, 96,  0, 32'hAA0BC0DD, 0, 0, 0);
      vecs[2]  = mk("lb96",   0, 3'b000, 96,  0, 32'hFFFFFFDD, 0, 0, 0);
      vecs[3]  = mk("lb97",   0, 3'b000, 97,  0, 32'hFFFFFFC0, 0, 0, 0);
      vecs[4]  = mk("lb98",   0, 3'b000, 98,  0, 32'h0000000B, 0, 0, 0);
      vecs[5]  = mk("lb99",   0, 3'b000, 99,  0, 32'hFFFFFFAA, 0, 0, 0);
      vecs[6]  = mk("lbu96",  0, 3'b100, 96,  0, 32'd221, 0, 0, 0);
      vecs[7]  = mk("lbu97",  0, 3'b100, 97,  0, 32'd192, 0, 0, 0);
      vecs[8]  = mk("lbu98",  0, 3'b100, 98,  0, 32'd11,  0, 0, 0);
      vecs[9]  = mk("lbu99",  0, 3'b100, 99,  0, 32'd170, 0, 0, 0);
      vecs[10] = mk("lh96",   0, 3'b001, 96,  0, 32'hFFFFC0DD, 0, 0, 0);
      vecs[11] = mk("lh97",   0, 3'b001, 97,  0, 32'd3008, 0, 0, 0);
      vecs[12] = mk("lh98",   0, 3'b001, 98,  0, 32'hFFFFAA0B, 0, 0, 0);
      vecs[13] = mk("lh99",   0, 3'b001, 99,  0, 32'hFFFFDDAA, 0, 0, 0);
      vecs[14] = mk("lhu98",  0, 3'b101, 98,  0, 32'd43531, 0, 0, 0);
      vecs[15] = mk("lhu99",  0, 3'b101, 99,  0, 32'd56746, 0, 0, 0);
      vecs[16] = mk("lw98err",0, 3'b010, 98,  0, 0, 1, 0, 0);
      vecs[17] = mk("sw98err",1, 3'b010, 98,  32'h12345678, 0, 1, 0, 0);
      vecs[18] = mk("lw96b",  0, 3'b010, 96,  0, 32'hAA0BC0DD, 0, 0, 0);
      vecs[19] = mk("ld111",  0, 3'b111, 96,  0, 0, 1, 0, 0);
      vecs[20] = mk("st100",  1, 3'b100, 96,  32'hFFFFFFFF, 0, 1, 0, 0);
      vecs[21] = mk("sb99",   1, 3'b000, 99,  32'h00000077, 0, 0, 1, 32'd1997258973);
      vecs[22] = mk("lw96c",  0, 3'b010, 96,  0, 32'h770BC0DD, 0, 0, 0);
      vecs[23] = mk("sh99",   1, 3'b001, 99,  32'h0000BEEF, 0, 0, 1, 32'hEF0BC0BE);
      vecs[24] = mk("lw96d",  0, 3'b010, 96,  0, 32'hEF0BC0BE, 0, 0, 0);
      vecs[25] = mk("sw352",  1, 3'b010, 352, 32'h11223344, 0, 0, 1, 32'h11223344);
      vecs[26] = mk("lw96w",  0, 3'b010, 96,  0, 32'h11223344, 0, 0, 0);
      vecs[27] = mk("sw96r",  1, 3'b010, 96,  32'hAA0BC0DD, 0, 0, 1, 32'hAA0BC0DD);

      reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
      #23 reset_n = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("reset");

      for (int i = 0; i < NV; i++) begin
         issue(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
         chk({vecs[i].name, "_valid"},    {31'd0, resp_valid}, 32'd1);
         chk({vecs[i].name, "_rdata"},    resp_rdata, vecs[i].rdata);
         chk({vecs[i].name, "_err"},      {31'd0, resp_err}, {31'd0, vecs[i].err});
         chk({vecs[i].name, "_st_valid"}, {31'd0, st_valid}, {31'd0, vecs[i].st});
         chk({vecs[i].name, "_ready_lo"}, {31'd0, req_ready}, 32'd0);
         if (vecs[i].st) begin
            exp_count++;
            chk({vecs[i].name, "_st_data"},  st_data, vecs[i].sdata);
            chk({vecs[i].name, "_st_addr"},  st_addr, {vecs[i].addr[31:2], 2'b00});
            chk({vecs[i].name, "_st_count"}, {16'd0, st_count}, exp_count);
         end
         finish_resp();
         chk({vecs[i].name, "_st_pulse_end"}, {31'd0, st_valid}, 32'd0);
      end

      // Stall with resp_ready low; a request offered meanwhile must be ignored.
      issue(1'b0, 3'b010, 96, 32'd0);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'd96; req_wdata = 32'd0;
      for (int c = 0; c < 5; c++) begin
         chk("stall_valid", {31'd0, resp_valid}, 32'd1);
         chk("stall_rdata", resp_rdata, 32'hAA0BC0DD);
         chk("stall_ready", {31'd0, req_ready}, 32'd0);
         chk("stall_no_st", {31'd0, st_valid}, 32'd0);
         @(posedge clk); #1;
      end
      req_valid = 1'b0; req_we = 1'b0;
      finish_resp();
      load_check("after_stall", 3'b010, 96, 32'hAA0BC0DD);

      // done flag: only a word store of 30 to byte address 40 sets it.
      issue(1'b1, 3'b000, 40, 32'd30); finish_resp(); exp_count++;
      chk("done_sb", {31'd0, done}, 32'd0);
      issue(1'b1, 3'b010, 44, 32'd30); finish_resp(); exp_count++;
      chk("done_wrong_addr", {31'd0, done}, 32'd0);
      issue(1'b1, 3'b010, 40, 32'd30); finish_resp(); exp_count++;
      chk("done_set", {31'd0, done}, 32'd1);
      issue(1'b1, 3'b010, 40, 32'd0); finish_resp(); exp_count++;
      chk("done_sticky", {31'd0, done}, 32'd1);
      chk("count_after_done", {16'd0, st_count}, exp_count);

      // Reset while a store response is pending.
      issue(1'b1, 3'b010, 100, 32'h00000055);
      chk("pre_reset_valid", {31'd0, resp_valid}, 32'd1);
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("midresp");
      #3 reset_n = 1'b1;
      exp_count = 0;
      @(posedge clk); #1;
      check_reset_outputs("postreset");
      load_check("mem_kept96", 3'b010, 96, 32'hAA0BC0DD);
      load_check("mem_kept100", 3'b010, 100, 32'h00000055);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
